// File: rtl/qmath_pkg.sv
// Shared definitions for the sign-magnitude Q-format arithmetic blocks (multiplier, divider).
package qmath_pkg;

    localparam int unsigned QM_N_DEF = 32;
    localparam int unsigned QM_Q_DEF = 15;

    // Wide enough for any supported word; blocks slice the magnitude width they need
    localparam int unsigned           QM_SAT_W    = 128;
    localparam logic [QM_SAT_W-1:0]   QM_SAT_ONES = '1;

    typedef enum logic [1:0] {
        QM_IDLE   = 2'd0,
        QM_CALC   = 2'd1,
        QM_FINISH = 2'd2
    } qm_state_e;

    // Iteration counter width; covers up to N+Q iterations including a guard step
    function automatic int unsigned qm_cnt_w(input int unsigned n, input int unsigned q);
        return $clog2(n + q + 1);
    endfunction

endpackage

// File: rtl/qdivs_step.sv
// One restoring-division step: shift the next dividend bit into the remainder, subtract if it fits.
module qdivs_step
#(
    parameter int unsigned N = 32
)
(
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-2:0] divisor_i,
    output logic [N-1:0] rem_c_o,
    output logic         qbit_c_o
);

    logic [N:0] trial_c;
    logic [N:0] diff_c;

    always_comb begin
        trial_c  = {rem_i, bit_i};
        diff_c   = trial_c - (N+1)'(divisor_i);
        qbit_c_o = (trial_c >= (N+1)'(divisor_i));
        rem_c_o  = qbit_c_o ? N'(diff_c) : N'(trial_c);
    end

endmodule

// File: rtl/qdivs.sv
// Sequential sign-magnitude Q-format restoring divider, one quotient bit per clock.
// Define QDIVS_ROUND_EN for a guard iteration with round-half-up; otherwise truncates.
module qdivs
    import qmath_pkg::*;
#(
    parameter int unsigned N = QM_N_DEF,
    parameter int unsigned Q = QM_Q_DEF
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_start,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow
);

`ifdef QDIVS_ROUND_EN
    localparam int unsigned GUARD = 1;
`else
    localparam int unsigned GUARD = 0;
`endif
    localparam int unsigned MW = N - 1;
    localparam int unsigned KW = MW + Q + GUARD;
    localparam int unsigned CW = qm_cnt_w(N, Q);

    qm_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  dvd_q, dvd_d;
    logic [MW-1:0]  dvs_q, dvs_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [KW-1:0]  quot_q, quot_d;
    logic           sign_q, sign_d;
    logic           dsign_q, dsign_d;
    logic [N-1:0]   result_q, result_d;
    logic           ovf_q, ovf_d;
    logic           complete_q, complete_d;

    logic [N-1:0]   step_rem_c;
    logic           step_qbit_c;
    logic [KW-1:0]  mag_full_c;
    logic           div_zero_c;
    logic           ovf_c;
    logic [MW-1:0]  mag_c;
    logic           sign_c;

    qdivs_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[KW-1]),
        .divisor_i (dvs_q),
        .rem_c_o   (step_rem_c),
        .qbit_c_o  (step_qbit_c)
    );

    // Final magnitude before saturation; the guard bit is the quotient LSB when rounding
`ifdef QDIVS_ROUND_EN
    assign mag_full_c = (quot_q >> 1) + KW'(quot_q[0]);
`else
    assign mag_full_c = quot_q;
`endif

    // Sign, saturation and zero handling applied in FINISH
    always_comb begin
        div_zero_c = (dvs_q == '0);
        ovf_c      = div_zero_c || ((mag_full_c >> MW) != '0);
        mag_c      = ovf_c ? QM_SAT_ONES[MW-1:0] : mag_full_c[MW-1:0];
        sign_c     = (div_zero_c ? dsign_q : sign_q) && (mag_c != '0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        sign_d     = sign_q;
        dsign_d    = dsign_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        complete_d = complete_q;

        unique case (state_q)
            QM_IDLE: begin
                if (i_start) begin
                    state_d    = QM_CALC;
                    cnt_d      = '0;
                    dvd_d      = KW'(i_dividend[N-2:0]) << (Q + GUARD);
                    dvs_d      = i_divisor[N-2:0];
                    rem_d      = '0;
                    quot_d     = '0;
                    sign_d     = i_dividend[N-1] ^ i_divisor[N-1];
                    dsign_d    = i_dividend[N-1];
                    complete_d = 1'b0;
                end
            end
            QM_CALC: begin
                rem_d  = step_rem_c;
                quot_d = KW'({quot_q, step_qbit_c});
                dvd_d  = dvd_q << 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(KW - 1)) begin
                    state_d = QM_FINISH;
                end
            end
            QM_FINISH: begin
                result_d   = {sign_c, mag_c};
                ovf_d      = ovf_c;
                complete_d = 1'b1;
                state_d    = QM_IDLE;
            end
            default: begin
                state_d    = QM_IDLE;
                complete_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= QM_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            sign_q     <= 1'b0;
            dsign_q    <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            complete_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            sign_q     <= sign_d;
            dsign_q    <= dsign_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            complete_q <= complete_d;
        end
    end

    assign o_quotient_out = result_q;
    assign o_complete     = complete_q;
    assign o_overflow     = ovf_q;

endmodule
